// File: rtl/dct_2d_8x8_ctrl.sv
// dct_2d_8x8_ctrl
// Block sequencer in front of dct_2d_8x8. It assembles a serial word stream
// into the flat matrix that drives the DCT and holds it for DCT_LATENCY cycles.
// It then captures the DCT result into an output buffer and streams that buffer
// out serially. Loading of the next block overlaps draining of the current one.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_data is one element, row-major
//   dct_in_matrix       to DCT data_in_matrix, word i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dct_out_matrix      from DCT data_out_matrix, same packing
//   out_valid/out_ready output handshake; out_data is one coefficient, row-major
//   out_last            high with the final word of each block
//   blocks_done         count of fully drained blocks (wraps)
module dct_2d_8x8_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int DATA_DEPTH  = 8,
    parameter int DCT_LATENCY = 4
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [DATA_WIDTH-1:0]                         in_data,
    output logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]   dct_in_matrix,
    input  logic [DATA_WIDTH*DATA_DEPTH*DATA_DEPTH-1:0]   dct_out_matrix,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DATA_WIDTH-1:0]                         out_data,
    output logic                                          out_last,
    output logic [15:0]                                   blocks_done
);

    localparam int NWORDS = DATA_DEPTH * DATA_DEPTH;
    localparam int IDX_W  = $clog2(NWORDS);
    localparam int CNT_W  = (DCT_LATENCY > 1) ? $clog2(DCT_LATENCY) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DCT_LATENCY - 1);

    typedef enum logic {LOAD, COMPUTE} state_t;

    state_t                            state, state_nxt;
    logic [IDX_W-1:0]                  wr_idx;
    logic [CNT_W-1:0]                  cnt;
    logic [DATA_WIDTH*NWORDS-1:0]      obuf;
    logic                              obuf_full;
    logic [IDX_W-1:0]                  rd_idx;

    logic accept, drain_take, drain_end, capture_ok, capture;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= LOAD;
        else          state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (accept && wr_idx == LAST_IDX) state_nxt = COMPUTE;
            COMPUTE: if (capture)                      state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // ---------------- outputs / handshake decode ----------------
    always_comb begin
        in_ready   = (state == LOAD);
        out_valid  = obuf_full;
        out_data   = obuf[rd_idx*DATA_WIDTH +: DATA_WIDTH];
        out_last   = obuf_full && (rd_idx == LAST_IDX);
        accept     = in_valid && in_ready;
        drain_take = out_valid && out_ready;
        drain_end  = drain_take && (rd_idx == LAST_IDX);
        // Buffer is free now, or its last word leaves on this very edge.
        capture_ok = !obuf_full || drain_end;
        capture    = (state == COMPUTE) && (cnt == CNT_MAX) && capture_ok;
    end

    // ---------------- input side: assemble matrix, count latency ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx        <= '0;
            cnt           <= '0;
            dct_in_matrix <= '0;
        end else begin
            if (accept) begin
                dct_in_matrix[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= in_data;
                wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
                if (wr_idx == LAST_IDX) cnt <= '0;
            end
            // Saturating count; holding at CNT_MAX is what a stall looks like.
            if (state == COMPUTE && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end
    end

    // ---------------- output side: buffer and drain ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            obuf        <= '0;
            obuf_full   <= 1'b0;
            rd_idx      <= '0;
            blocks_done <= '0;
        end else begin
            if (drain_take) begin
                if (drain_end) begin
                    rd_idx      <= '0;
                    blocks_done <= blocks_done + 16'd1;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
            if (capture) begin
                obuf      <= dct_out_matrix;
                obuf_full <= 1'b1;
                rd_idx    <= '0;
            end else if (drain_end) begin
                obuf_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dct_2d_8x8_ctrl.sv
// Directed bench for dct_2d_8x8_ctrl with a pass-through DCT stub.
module tb_dct_2d_8x8_ctrl;

    localparam int DW = 32;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [DW*64-1:0] dct_in_matrix;
    logic [DW*64-1:0] dct_out_matrix;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [15:0]     blocks_done;

    int vectors     = 0;
    int miscompares = 0;

    assign dct_out_matrix = dct_in_matrix;

    dct_2d_8x8_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(8), .DCT_LATENCY(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dct_in_matrix(dct_in_matrix), .dct_out_matrix(dct_out_matrix),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .blocks_done(blocks_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed 64 words base+i; duty is the percent chance in_valid is offered per cycle.
    task automatic load(input logic [31:0] base, input int duty);
        int  i;
        int  guard;
        bit  acc;
        i = 0;
        guard = 0;
        while (i < 64 && guard < 5000) begin
            in_valid = ($urandom_range(0, 99) < duty);
            in_data  = in_valid ? base + i : 32'hDEAD_BEEF;
            acc = in_valid && in_ready;
            step();
            guard++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        chk("load_words", i, 64);
    endtask

    // Drain n words starting at index first; toggle alternates out_ready 1,0,1,0.
    task automatic drain(input logic [31:0] base, input int first, input int n,
                         input bit toggle, input int max_wait);
        int j;
        int waited;
        int guard;
        bit rdy;
        j = first;
        waited = 0;
        guard = 0;
        rdy = 1'b1;
        while (!out_valid && waited < max_wait) begin
            step();
            waited++;
        end
        chk("out_valid_rise", out_valid, 1);
        if (!out_valid) return;
        while (j < first + n && guard < 1000) begin
            chk("out_valid", out_valid, 1);
            chk("out_data", out_data, base + j);
            chk("out_last", out_last, (j == 63));
            out_ready = toggle ? rdy : 1'b1;
            rdy = !rdy;
            step();
            guard++;
            if (out_ready) j++;
        end
        out_ready = 1'b0;
        chk("drain_words", j, first + n);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // 1. Reset state, then an asynchronous reset in the middle of a load.
        step(); step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_blocks", blocks_done, 0);
        chk("rst_matrix_zero", dct_in_matrix == '0, 1);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h1 + k;
            step();
        end
        in_valid = 1'b0;
        chk("partial_word0", dct_in_matrix[31:0], 32'h1);
        reset_n = 1'b0;
        #1;
        chk("async_matrix_zero", dct_in_matrix == '0, 1);
        chk("async_in_ready", in_ready, 1);
        #1 reset_n = 1'b1;
        step();

        // 2. Single block, exact latency, in-order output.
        out_ready = 1'b1;
        load(32'h100, 100);
        chk("lat_in_ready_0", in_ready, 0);
        chk("lat_out_valid_0", out_valid, 0);
        for (int k = 1; k < 4; k++) begin
            step();
            chk("lat_in_ready", in_ready, 0);
            chk("lat_out_valid", out_valid, 0);
        end
        step();
        chk("lat_in_ready_4", in_ready, 1);
        chk("lat_out_valid_4", out_valid, 1);
        drain(32'h100, 0, 64, 1'b0, 0);
        chk("single_valid_drop", out_valid, 0);
        chk("single_blocks", blocks_done, 1);

        // 3. Backpressure with out_ready toggling.
        load(32'h200, 100);
        drain(32'h200, 0, 64, 1'b1, 10);
        chk("bp_blocks", blocks_done, 2);

        // 4. Block B stalls in COMPUTE behind A, then hands off with no bubble.
        load(32'hA00, 100);
        load(32'hB00, 100);
        for (int k = 0; k < 10; k++) step();
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_out_data", out_data, 32'hA00);
        drain(32'hA00, 0, 64, 1'b0, 0);
        drain(32'hB00, 0, 64, 1'b0, 0);
        chk("overlap_blocks", blocks_done, 4);

        // 5. Sparse input at roughly 30% duty.
        load(32'h500, 30);
        drain(32'h500, 0, 64, 1'b0, 10);
        chk("gap_blocks", blocks_done, 5);

        // 6. Reset after 20 words drained; a fresh block must start from word 0.
        load(32'h600, 100);
        drain(32'h600, 0, 20, 1'b0, 10);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_blocks", blocks_done, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        #1 reset_n = 1'b1;
        step();
        chk("post_rst_idle", out_valid, 0);
        load(32'h700, 100);
        drain(32'h700, 0, 64, 1'b0, 10);
        chk("post_rst_blocks", blocks_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
